// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
//   arb_state_e : controller state (clear sweep / normal arbitration)
//   req_idx_e   : requester index, also used as the round-robin pointer value
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    CLEAR,
    RUN
  } arb_state_e;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a registered priority pointer.
//   Clk : clock, state on rising edge
//   Rst : asynchronous active-high reset (pointer -> REQ_A)
//   Req : request vector, bit 0 = A, bit 1 = B
//   Gnt : combinational one-hot grant (or zero when nothing requests)
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Req,
  output logic [1:0] Gnt
);

  req_idx_e ptr_q, ptr_d;

  always_comb begin
    Gnt   = 2'b00;
    ptr_d = ptr_q;
    case (Req)
      2'b01:   Gnt = 2'b01;
      2'b10:   Gnt = 2'b10;
      2'b11:   Gnt = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
      default: Gnt = 2'b00;
    endcase
    // Priority passes to the loser of every grant, contested or not.
    if (Gnt[0]) begin
      ptr_d = REQ_B;
    end else if (Gnt[1]) begin
      ptr_d = REQ_A;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram1024x8_arbiter.sv
// Two-requester controller for an external simple dual-port RAM.
// After reset an optional sweep writes CLEAR_VAL to every word; afterwards the
// write port and the read port are each round-robin arbitrated between A and B.
//   Clk, Rst                  : clock, asynchronous active-high reset
//   A_/B_Valid, We, Addr, WData : requests (held stable until Ready)
//   A_/B_Ready                : combinational grant
//   A_/B_RspValid, RspData    : read response, one cycle after the read grant
//   WA, WD, WEN               : RAM write port
//   RA, RD                    : RAM read port (RD registered inside the RAM)
//   Busy                      : clear sweep in progress
module ram1024x8_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter bit                CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              A_Valid,
  input  logic              A_We,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_WData,
  input  logic              B_Valid,
  input  logic              B_We,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_WData,
  output logic              A_Ready,
  output logic              B_Ready,
  output logic              A_RspValid,
  output logic              B_RspValid,
  output logic [DATA_W-1:0] A_RspData,
  output logic [DATA_W-1:0] B_RspData,
  output logic [ADDR_W-1:0] WA,
  output logic [ADDR_W-1:0] RA,
  output logic [DATA_W-1:0] WD,
  output logic              WEN,
  input  logic [DATA_W-1:0] RD,
  output logic              Busy
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] wa_q, ra_q;
  logic [DATA_W-1:0] wd_q;
  logic              a_rsp_q, b_rsp_q;
  logic              run;
  logic [1:0]        wr_req, rd_req, wr_gnt, rd_gnt;

  assign run    = (state_q == RUN);
  // Requests are masked during the sweep so the pointers do not move.
  assign wr_req = {B_Valid & B_We, A_Valid & A_We} & {2{run}};
  assign rd_req = {B_Valid & ~B_We, A_Valid & ~A_We} & {2{run}};

  rr_arb2 u_wr_arb (
    .Clk (Clk),
    .Rst (Rst),
    .Req (wr_req),
    .Gnt (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .Clk (Clk),
    .Rst (Rst),
    .Req (rd_req),
    .Gnt (rd_gnt)
  );

  assign A_Ready    = wr_gnt[0] | rd_gnt[0];
  assign B_Ready    = wr_gnt[1] | rd_gnt[1];
  assign A_RspValid = a_rsp_q;
  assign B_RspValid = b_rsp_q;
  assign A_RspData  = RD;
  assign B_RspData  = RD;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    WEN       = 1'b0;
    WA        = wa_q;
    WD        = wd_q;
    RA        = ra_q;
    Busy      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        WEN       = 1'b1;
        WA        = clr_cnt_q;
        WD        = CLEAR_VAL;
        Busy      = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr_gnt[0]) begin
          WEN = 1'b1;
          WA  = A_Addr;
          WD  = A_WData;
        end else if (wr_gnt[1]) begin
          WEN = 1'b1;
          WA  = B_Addr;
          WD  = B_WData;
        end
        if (rd_gnt[0]) begin
          RA = A_Addr;
        end else if (rd_gnt[1]) begin
          RA = B_Addr;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= CLEAR_EN ? CLEAR : RUN;
      clr_cnt_q <= '0;
      wa_q      <= '0;
      ra_q      <= '0;
      wd_q      <= '0;
      a_rsp_q   <= 1'b0;
      b_rsp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      // Port buses keep whatever was last driven when nothing is granted.
      wa_q      <= WA;
      ra_q      <= RA;
      wd_q      <= WD;
      a_rsp_q   <= rd_gnt[0];
      b_rsp_q   <= rd_gnt[1];
    end
  end

endmodule
